// File: rtl/rtc_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rtc_bus_responder
// Purpose  : In-FPGA emulation of the multiplexed A/D RTC register file.
//            Synchronizes the asynchronous bus strobes, latches the address
//            on an address-phase write, commits data on a data-phase write
//            and drives register contents onto the AD bus during reads.
//            Also offers a committed-write stream and a local read port.
// Revision : 1.0  initial release
// ============================================================================
module rtc_bus_responder #(
  parameter int DATA_W      = 8,
  parameter int NREGS       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_d,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              wr_stb,
  output logic [7:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [7:0]        loc_addr,
  output logic [DATA_W-1:0] loc_data,
  output logic              proto_err
);

  // Bus inputs are packed as {a_d, cs, rd, wr, ad_in} through the synchronizer.
  localparam int BUS_W = DATA_W + 4;
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [BUS_W-1:0] C_BUS_IDLE = {4'b1111, {DATA_W{1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  logic [BUS_W-1:0]  r_sync [SYNC_STAGES];
  logic [BUS_W-1:0]  r_hist;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [7:0]        r_addr;
  logic              r_addr_valid;
  logic              r_collide;
  logic              r_c_both_q;
  logic              r_c_addr_q;
  logic              r_wr_stb;
  logic [7:0]        r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_loc_data;
  logic              r_proto;
  logic [DATA_W-1:0] r_ad_out;
  logic              r_ad_oe;
  state_t            r_state;
  state_t            w_next_state;

  logic [BUS_W-1:0]  w_s;
  logic              w_s_a_d, w_s_cs, w_s_rd, w_s_wr;
  logic              w_p_a_d, w_p_cs, w_p_rd, w_p_wr;
  logic [DATA_W-1:0] w_p_ad;
  logic [7:0]        w_p_addr;
  logic              w_wr_rise, w_wr_block, w_addr_ev, w_data_ev;
  logic              w_addr_in_range, w_commit;
  logic              w_c_both, w_c_addr_rd, w_c_noaddr, w_rd_fall;
  logic              w_drive_ok;
  logic [DATA_W-1:0] w_rd_data;

  // Synchronizer chain plus one history stage for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= C_BUS_IDLE;
      r_hist <= C_BUS_IDLE;
    end else begin
      r_sync[0] <= {a_d, cs, rd, wr, ad_in};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_s_a_d = w_s[DATA_W+3];
  assign w_s_cs  = w_s[DATA_W+2];
  assign w_s_rd  = w_s[DATA_W+1];
  assign w_s_wr  = w_s[DATA_W];
  assign w_p_a_d = r_hist[DATA_W+3];
  assign w_p_cs  = r_hist[DATA_W+2];
  assign w_p_rd  = r_hist[DATA_W+1];
  assign w_p_wr  = r_hist[DATA_W];
  assign w_p_ad  = r_hist[DATA_W-1:0];

  // Address is always 8 bits regardless of the bus width.
  generate
    if (DATA_W >= 8) begin : g_addr_trunc
      assign w_p_addr = w_p_ad[7:0];
    end else begin : g_addr_pad
      assign w_p_addr = {{(8-DATA_W){1'b0}}, w_p_ad};
    end
  endgenerate

  // A write that overlapped a read strobe is discarded.
  assign w_wr_rise       = ~w_p_wr & w_s_wr & ~w_p_cs;
  assign w_wr_block      = r_collide | ~w_p_rd;
  assign w_addr_ev       = w_wr_rise & ~w_p_a_d & ~w_wr_block;
  assign w_data_ev       = w_wr_rise & w_p_a_d & r_addr_valid & ~w_wr_block;
  assign w_addr_in_range = (32'(r_addr) < NREGS);
  assign w_commit        = w_data_ev & w_addr_in_range;

  assign w_c_both    = ~w_s_cs & ~w_s_rd & ~w_s_wr;
  assign w_c_addr_rd = ~w_s_cs & ~w_s_rd & ~w_s_a_d;
  assign w_rd_fall   = w_p_rd & ~w_s_rd;
  assign w_c_noaddr  = w_rd_fall & ~w_s_cs & w_s_a_d & ~r_addr_valid;
  assign w_drive_ok  = ~w_s_cs & ~w_s_rd & w_s_wr & w_s_a_d & r_addr_valid;

  // Address latch; it persists until the next address phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr       <= 8'd0;
      r_addr_valid <= 1'b0;
    end else if (w_addr_ev) begin
      r_addr       <= w_p_addr;
      r_addr_valid <= 1'b1;
    end
  end

  // Register file: committed data-phase writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[r_addr[IDX_W-1:0]] <= w_p_ad;
    end
  end

  // Committed-write notification stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_stb  <= 1'b0;
      r_wr_addr <= 8'd0;
      r_wr_data <= '0;
    end else begin
      r_wr_stb <= w_commit;
      if (w_commit) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_p_ad;
      end
    end
  end

  // Local read port; a same-cycle write shows up one clock later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_loc_data <= '0;
    end else if (32'(loc_addr) < NREGS) begin
      r_loc_data <= r_regs[loc_addr[IDX_W-1:0]];
    end else begin
      r_loc_data <= '0;
    end
  end

  // Protocol violation detection, pulsed on the onset of each condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_proto    <= 1'b0;
      r_c_both_q <= 1'b0;
      r_c_addr_q <= 1'b0;
      r_collide  <= 1'b0;
    end else begin
      r_proto    <= (w_c_both & ~r_c_both_q) | (w_c_addr_rd & ~r_c_addr_q) | w_c_noaddr;
      r_c_both_q <= w_c_both;
      r_c_addr_q <= w_c_addr_rd;
      r_collide  <= w_c_both | (r_collide & ~w_s_wr);
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Read FSM next state and read-data selection.
  always_comb begin
    w_next_state = r_state;
    w_rd_data    = '0;
    if (w_addr_in_range) w_rd_data = r_regs[r_addr[IDX_W-1:0]];
    case (r_state)
      ST_IDLE:  if (w_drive_ok) w_next_state = ST_DRIVE;
      ST_DRIVE: if (w_s_cs | w_s_rd | ~w_s_a_d | ~w_s_wr) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Registered bus drive; reset releases the bus immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ad_oe  <= 1'b0;
      r_ad_out <= '0;
    end else begin
      r_ad_oe  <= (w_next_state == ST_DRIVE);
      r_ad_out <= (w_next_state == ST_DRIVE) ? w_rd_data : '0;
    end
  end

  assign ad_out    = r_ad_out;
  assign ad_oe     = r_ad_oe;
  assign wr_stb    = r_wr_stb;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign loc_data  = r_loc_data;
  assign proto_err = r_proto;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rtc_bus_responder
// Purpose  : Scoreboard bench for rtc_bus_responder; stimulus queues the
//            expected responses, a monitor compares them as they appear.
// Revision : 1.0  initial release
// ============================================================================
module tb_rtc_bus_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_d, cs, rd, wr;
  logic [7:0] ad_in, loc_addr;
  logic [7:0] ad_out, wr_addr, wr_data, loc_data;
  logic       ad_oe, wr_stb, proto_err;

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; logic [7:0] data; } loc_t;

  wr_t        q_wr[$];
  logic [7:0] q_drv[$];
  int         q_proto[$];
  loc_t       q_loc[$];

  int cyc = 0;
  int rd_fall_cyc = 0;
  int rd_rise_cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  rtc_bus_responder #(.DATA_W(8), .NREGS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data), .loc_addr(loc_addr),
    .loc_data(loc_data), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency bookkeeping.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_addr(input logic [7:0] a);
    a_d = 1'b0; cs = 1'b0; ad_in = a;
    nclk(2); wr = 1'b0; nclk(5); wr = 1'b1; nclk(2); cs = 1'b1; nclk(3);
  endtask

  task automatic bus_write(input logic [7:0] d, input bit exp_stb, input logic [7:0] exp_addr);
    a_d = 1'b1; cs = 1'b0; ad_in = d;
    nclk(2); wr = 1'b0; nclk(5);
    if (exp_stb) q_wr.push_back('{exp_addr, d});
    wr = 1'b1; nclk(2); cs = 1'b1; nclk(3);
  endtask

  task automatic bus_read(input int hold, input bit exp_drv, input logic [7:0] exp_data,
                          input bit exp_proto);
    a_d = 1'b1; cs = 1'b0; ad_in = 8'h00;
    nclk(2);
    if (exp_drv) q_drv.push_back(exp_data);
    if (exp_proto) q_proto.push_back(1);
    rd = 1'b0; rd_fall_cyc = cyc;
    nclk(hold);
    rd = 1'b1; rd_rise_cyc = cyc;
    nclk(5); cs = 1'b1; nclk(3);
  endtask

  task automatic loc_read(input logic [7:0] a, input logic [7:0] e);
    loc_addr = a;
    q_loc.push_back('{cyc + 1, e});
    nclk(2);
  endtask

  // Monitor: compares DUT outputs against queued expectations.
  initial begin
    logic prev_oe;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (wr_stb) begin
          chk("wr_stb_expected", 32'(q_wr.size() > 0), 1);
          if (q_wr.size() > 0) begin
            chk("wr_addr", wr_addr, q_wr[0].addr);
            chk("wr_data", wr_data, q_wr[0].data);
            void'(q_wr.pop_front());
          end
        end
        if (proto_err) begin
          chk("proto_expected", 32'(q_proto.size() > 0), 1);
          if (q_proto.size() > 0) void'(q_proto.pop_front());
        end
        if (ad_oe && !prev_oe) begin
          chk("drive_expected", 32'(q_drv.size() > 0), 1);
          if (q_drv.size() > 0) begin
            chk("ad_out", ad_out, q_drv[0]);
            void'(q_drv.pop_front());
          end
          chk("oe_rise_latency", cyc - rd_fall_cyc, 3);
        end
        if (!ad_oe && prev_oe) chk("oe_fall_latency", cyc - rd_rise_cyc, 3);
        while (q_loc.size() > 0 && q_loc[0].cyc == cyc) begin
          chk("loc_data", loc_data, q_loc[0].data);
          void'(q_loc.pop_front());
        end
      end
      prev_oe = ad_oe;
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    reset = 1'b1; a_d = 1'b1; cs = 1'b1; rd = 1'b1; wr = 1'b1;
    ad_in = 8'h00; loc_addr = 8'h00;
    nclk(3);
    chk("rst_ad_oe", ad_oe, 0);
    chk("rst_ad_out", ad_out, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_loc_data", loc_data, 0);
    chk("rst_proto_err", proto_err, 0);
    reset = 1'b0;
    nclk(3);

    // Read with no latched address: violation, no drive.
    bus_read(5, 1'b0, 8'h00, 1'b1);

    // rd and wr low together: violation, no register change.
    bus_addr(8'h07);
    a_d = 1'b1; cs = 1'b0; ad_in = 8'hAA;
    nclk(2);
    q_proto.push_back(1);
    rd = 1'b0; wr = 1'b0;
    nclk(5);
    rd = 1'b1; wr = 1'b1;
    nclk(2); cs = 1'b1; nclk(3);
    loc_read(8'h07, 8'h00);

    // Basic write and read-back.
    bus_addr(8'h05);
    bus_write(8'h3C, 1'b1, 8'h05);
    loc_read(8'h05, 8'h3C);
    bus_addr(8'h05);
    bus_read(8, 1'b1, 8'h3C, 1'b0);

    // Out-of-range address: write dropped, read drives zero.
    bus_addr(8'h20);
    bus_write(8'h55, 1'b0, 8'h20);
    bus_read(6, 1'b1, 8'h00, 1'b0);
    loc_read(8'h20, 8'h00);

    // Back-to-back writes and reads.
    bus_addr(8'h03);
    bus_write(8'h11, 1'b1, 8'h03);
    bus_addr(8'h04);
    bus_write(8'h22, 1'b1, 8'h04);
    bus_addr(8'h03);
    bus_read(5, 1'b1, 8'h11, 1'b0);
    bus_addr(8'h04);
    bus_read(5, 1'b1, 8'h22, 1'b0);
    loc_read(8'h03, 8'h11);

    // Repeated data write without a new address phase, local read in the commit cycle.
    a_d = 1'b1; cs = 1'b0; ad_in = 8'h99;
    nclk(2); wr = 1'b0; nclk(5);
    q_wr.push_back('{8'h04, 8'h99});
    wr = 1'b1;
    nclk(2);
    loc_addr = 8'h04;
    q_loc.push_back('{cyc + 1, 8'h22});
    q_loc.push_back('{cyc + 2, 8'h99});
    nclk(3); cs = 1'b1; nclk(3);

    // Reset in the middle of a read.
    bus_addr(8'h05);
    a_d = 1'b1; cs = 1'b0;
    nclk(2);
    q_drv.push_back(8'h3C);
    rd = 1'b0; rd_fall_cyc = cyc;
    nclk(5);
    chk("oe_before_reset", ad_oe, 1);
    reset = 1'b1;
    #1;
    chk("reset_ad_oe", ad_oe, 0);
    chk("reset_ad_out", ad_out, 0);
    rd = 1'b1; cs = 1'b1;
    nclk(2);
    reset = 1'b0;
    nclk(2);
    loc_read(8'h03, 8'h00);
    loc_read(8'h04, 8'h00);
    loc_read(8'h05, 8'h00);
    chk("post_reset_wr_addr", wr_addr, 0);

    nclk(10);
    chk("q_wr_empty", q_wr.size(), 0);
    chk("q_drv_empty", q_drv.size(), 0);
    chk("q_proto_empty", q_proto.size(), 0);
    chk("q_loc_empty", q_loc.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
